// File: rtl/gpio_pud_sequencer_if.sv
// gpio_pud_sequencer_if: pad-mode configuration request/ready channel
interface gpio_pud_sequencer_if #(parameter int CH_W = 6);
  logic            cfg_valid;
  logic            cfg_ready;
  logic [CH_W-1:0] cfg_channel;
  logic [1:0]      cfg_mode;
  modport master(output cfg_valid, cfg_channel, cfg_mode, input cfg_ready);
  modport slave(input cfg_valid, cfg_channel, cfg_mode, output cfg_ready);
endinterface

// File: rtl/gpio_pud_sequencer.sv
// gpio_pud_sequencer: walks every GPIO channel through pull-down, pull-up and disabled, publishing checkpoint codes
module gpio_pud_sequencer #(
  parameter int NUM_CH      = 38,
  parameter int CH_W        = 6,
  parameter int HOLD_CYCLES = 1000,
  parameter int CNT_W       = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NUM_CH-1:0]       skip_mask,
  gpio_pud_sequencer_if.master    cfg,
  output logic [5:0]              checkbits,
  output logic                    busy,
  output logic                    done
);
  if (HOLD_CYCLES < 1 || HOLD_CYCLES >= (1 << CNT_W)) begin : g_bad_hold
    $error("HOLD_CYCLES must lie in 1..2^CNT_W-1");
  end
  if ((1 << CH_W) < NUM_CH) begin : g_bad_ch_w
    $error("CH_W too narrow for NUM_CH");
  end
  localparam logic [5:0] CODE_START = 6'h30;
  localparam logic [5:0] CODE_PD    = 6'h31;
  localparam logic [5:0] CODE_PU    = 6'h32;
  localparam logic [5:0] CODE_DIS   = 6'h33;
  localparam logic [5:0] CODE_DONE  = 6'h34;
  typedef enum logic [3:0] {
    IDLE, ANNOUNCE, CFG_PD, HOLD_PD, CFG_PU, HOLD_PU, CFG_DIS, HOLD_DIS, DONE
  } state_t;
  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [CH_W-1:0]   ch, ch_n;
  logic [NUM_CH-1:0] mask, mask_n;
  logic [5:0]        code_n;
  logic              timed, hold_end, cfg_phase, skip, accept, last;
  assign timed     = state inside {ANNOUNCE, HOLD_PD, HOLD_PU, HOLD_DIS};
  assign hold_end  = cnt == CNT_W'(HOLD_CYCLES - 1);
  assign cfg_phase = state inside {CFG_PD, CFG_PU, CFG_DIS};
  assign skip      = mask[ch];
  assign accept    = cfg_phase && (skip || cfg.cfg_ready);
  assign last      = ch == CH_W'(NUM_CH - 1);
  always_comb begin
    state_n = state;
    ch_n    = ch;
    mask_n  = mask;
    code_n  = checkbits;
    cnt_n   = timed && !hold_end ? cnt + 1'b1 : '0;
    case (state)
      IDLE, DONE: if (start) begin
        state_n = ANNOUNCE;
        ch_n    = '0;
        mask_n  = skip_mask;
        code_n  = CODE_START;
      end
      ANNOUNCE: state_n = hold_end ? CFG_PD : state;
      CFG_PD:   if (accept) begin state_n = HOLD_PD;  code_n = CODE_PD;  end
      HOLD_PD:  state_n = hold_end ? CFG_PU : state;
      CFG_PU:   if (accept) begin state_n = HOLD_PU;  code_n = CODE_PU;  end
      HOLD_PU:  state_n = hold_end ? CFG_DIS : state;
      CFG_DIS:  if (accept) begin state_n = HOLD_DIS; code_n = CODE_DIS; end
      HOLD_DIS: if (hold_end) begin
        state_n = last ? DONE : CFG_PD;
        ch_n    = last ? ch : ch + 1'b1;
        code_n  = last ? CODE_DONE : checkbits;
      end
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ch        <= '0;
      mask      <= '0;
      checkbits <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ch        <= ch_n;
      mask      <= mask_n;
      checkbits <= code_n;
    end
  end
  assign cfg.cfg_valid   = cfg_phase && !skip;
  assign cfg.cfg_channel = ch;
  assign cfg.cfg_mode    = state == CFG_PD ? 2'b01 : state == CFG_PU ? 2'b10 : 2'b00;
  assign busy            = !(state inside {IDLE, DONE});
  assign done            = state == DONE;
endmodule

// File: tb/tb_gpio_pud_sequencer.sv
// tb_gpio_pud_sequencer: random-ready bench checking the sequencer against a step-indexed model
module tb_gpio_pud_sequencer;
  localparam int N = 38;
  localparam int H = 4;
  logic clock = 0, reset = 0, start = 0;
  logic [N-1:0] skip_mask = '0;
  logic [5:0] checkbits;
  logic busy, done;
  gpio_pud_sequencer_if #(.CH_W(6)) bus();
  gpio_pud_sequencer #(.NUM_CH(N), .CH_W(6), .HOLD_CYCLES(H), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .start(start), .skip_mask(skip_mask),
    .cfg(bus.master), .checkbits(checkbits), .busy(busy), .done(done));
  always #5 clock = ~clock;
  int vectors = 0, miscompares = 0, hs = 0, rdy_mode = 0, stall_cnt = 0;
  bit chk_en = 0;
  // model: step 0 is the announcement, step k>=1 is channel (k-1)/3 in mode (k-1)%3
  bit m_act = 0, m_done = 0, m_req = 0, exp_v;
  int m_k = 0, m_age = 0;
  logic [N-1:0] m_mask = '0;
  logic [5:0] m_code = '0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic logic [5:0] code_of(int k);
    return k == 0 ? 6'h30 : 6'h31 + 6'((k - 1) % 3);
  endfunction
  function automatic logic [1:0] mode_of(int i);
    return i == 0 ? 2'b01 : i == 1 ? 2'b10 : 2'b00;
  endfunction
  function automatic bit m_skip();
    return m_k > 0 && m_mask[(m_k - 1) / 3];
  endfunction
  always @(posedge clock) begin
    if (reset) begin
      m_act = 0; m_done = 0; m_req = 0; m_k = 0; m_age = 0; m_code = 6'h00;
    end else if (!m_act) begin
      if (start) begin
        m_act = 1; m_done = 0; m_req = 0; m_k = 0; m_age = 0; m_mask = skip_mask; m_code = 6'h30;
      end
    end else if (m_req) begin
      if (m_skip() || bus.cfg_ready) begin m_req = 0; m_age = 0; m_code = code_of(m_k); end
    end else if (m_age == H - 1) begin
      if (m_k == 3 * N) begin m_act = 0; m_done = 1; m_code = 6'h34; end
      else begin m_k++; m_req = 1; end
    end else m_age++;
  end
  always @(negedge clock) if (chk_en) begin
    if (bus.cfg_valid && bus.cfg_ready) hs++;
    chk("checkbits", checkbits, m_code);
    chk("busy", busy, m_act);
    chk("done", done, m_done);
    exp_v = m_act && m_req && !m_skip();
    chk("cfg_valid", bus.cfg_valid, exp_v);
    if (exp_v) begin
      chk("cfg_channel", bus.cfg_channel, (m_k - 1) / 3);
      chk("cfg_mode", bus.cfg_mode, mode_of((m_k - 1) % 3));
    end
  end
  initial begin
    bus.cfg_ready = 1;
    forever begin
      @(posedge clock); #1;
      if (rdy_mode == 0) bus.cfg_ready = 1;
      else if (rdy_mode == 1) bus.cfg_ready = $urandom_range(0, 3) != 0;
      else if (stall_cnt == 0 && bus.cfg_valid && bus.cfg_channel == 5 && bus.cfg_mode == 2'b10) begin
        bus.cfg_ready = 0; stall_cnt = 1;
      end else if (stall_cnt > 0 && stall_cnt < 10) begin
        chk("stall_valid", bus.cfg_valid, 1);
        chk("stall_channel", bus.cfg_channel, 5);
        chk("stall_mode", bus.cfg_mode, 2'b10);
        chk("stall_code", checkbits, 6'h31);
        bus.cfg_ready = 0; stall_cnt++;
      end else bus.cfg_ready = 1;
    end
  end
  task automatic pulse_start(input logic [N-1:0] m);
    @(posedge clock); #1;
    hs = 0; skip_mask = m; start = 1;
    @(posedge clock); #1;
    start = 0;
  endtask
  task automatic wait_done(input int bound);
    int c = 0;
    do begin @(negedge clock); c++; end while (done !== 1'b1 && c < bound);
    if (done !== 1'b1) chk("done_timeout", done, 1);
  endtask
  initial begin
    int cyc;
    logic [N-1:0] m;
    reset = 1;
    repeat (3) @(posedge clock);
    #1 reset = 0; chk_en = 1;
    @(negedge clock);
    chk("rst_checkbits", checkbits, 6'h00);
    chk("rst_valid", bus.cfg_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_channel", bus.cfg_channel, 0);
    chk("rst_mode", bus.cfg_mode, 2'b00);
    pulse_start('0);
    cyc = 0;
    do begin
      @(negedge clock); cyc++;
      if (cyc == 1) chk("announce_first", checkbits, 6'h30);
      if (cyc == 5) chk("announce_last", checkbits, 6'h30);
      if (cyc == 6) chk("first_pd", checkbits, 6'h31);
      if (cyc == 100) begin start = 1; skip_mask = '1; end
      if (cyc == 101) start = 0;
    end while (done !== 1'b1 && cyc < 2000);
    chk("done_cycle", cyc, 5 + 114 * 5);
    chk("handshakes_full", hs, 114);
    rdy_mode = 1;
    m = '0;
    for (int i = 14; i <= 24; i++) m[i] = 1'b1;
    pulse_start(m);
    @(negedge clock);
    chk("restart_done", done, 0);
    chk("restart_code", checkbits, 6'h30);
    wait_done(20000);
    chk("handshakes_skip", hs, 81);
    rdy_mode = 2; stall_cnt = 0;
    pulse_start('0);
    cyc = 0;
    do begin @(negedge clock); cyc++; end
    while (!(checkbits == 6'h32 && bus.cfg_channel == 7) && cyc < 5000);
    chk("reach_ch7_pu", {bus.cfg_channel, checkbits}, {6'd7, 6'h32});
    chk("stall_len", stall_cnt, 10);
    @(posedge clock); #1 reset = 1;
    @(posedge clock); #1 reset = 0;
    @(negedge clock);
    chk("abort_code", checkbits, 6'h00);
    chk("abort_valid", bus.cfg_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    rdy_mode = 1;
    m = N'({$urandom, $urandom});
    pulse_start(m);
    @(negedge clock);
    chk("fresh_code", checkbits, 6'h30);
    chk("fresh_channel", bus.cfg_channel, 0);
    wait_done(20000);
    chk("handshakes_rand", hs, 3 * (N - $countones(m)));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
